// File: rtl/booth_mul_issue_ctrl.sv
// Operand issue / result capture stage around a sequential radix-4 Booth multiplier.
// Optional watchdog abort of a stuck multiply: define BOOTH_ISSUE_TIMEOUT_EN.
module booth_mul_issue_ctrl #(
   parameter int FIFO_DEPTH  = 4,
   parameter int MUL_TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_en,
   output logic        mul_reset,
   input  logic [63:0] mul_result,
   input  logic        mul_done,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic        out_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   typedef enum logic [1:0] {IDLE, RST, RUN} state_t;

   state_t      state;
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [31:0] mem_a [FIFO_DEPTH];
   logic [31:0] mem_b [FIFO_DEPTH];
   logic        full;
   logic        empty;
   logic        push;
   logic        launch;

   // The extra pointer bit separates a full FIFO from an empty one.
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign in_ready = reset && !full;
   assign push     = in_valid && in_ready;
   assign launch   = (state == IDLE) && !empty && (!out_valid || out_ready);

   // NOTE: operand storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr[AW-1:0]] <= in_a;
         mem_b[wr_ptr[AW-1:0]] <= in_b;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PTR_ONE;
      end
   end

`ifdef BOOTH_ISSUE_TIMEOUT_EN
   logic [15:0] timer;
`else
   assign out_err = 1'b0;
`endif

   // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         mul_a      <= '0;
         mul_b      <= '0;
         mul_en     <= 1'b0;
         mul_reset  <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
`ifdef BOOTH_ISSUE_TIMEOUT_EN
         out_err    <= 1'b0;
         timer      <= '0;
`endif
      end else begin
         // Drain first; a capture later in this block takes priority.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (launch) begin
                  mul_a     <= mem_a[rd_ptr[AW-1:0]];
                  mul_b     <= mem_b[rd_ptr[AW-1:0]];
                  rd_ptr    <= rd_ptr + PTR_ONE;
                  mul_en    <= 1'b1;
                  mul_reset <= 1'b1;
                  state     <= RST;
               end
            end

            RST: begin
               mul_reset <= 1'b0;
               state     <= RUN;
`ifdef BOOTH_ISSUE_TIMEOUT_EN
               timer     <= '0;
`endif
            end

            RUN: begin
               if (mul_done) begin
                  out_result <= mul_result;
                  out_valid  <= 1'b1;
                  mul_en     <= 1'b0;
                  state      <= IDLE;
`ifdef BOOTH_ISSUE_TIMEOUT_EN
                  out_err    <= 1'b0;
               end else if (timer == 16'(MUL_TIMEOUT - 1)) begin
                  out_result <= '0;
                  out_err    <= 1'b1;
                  out_valid  <= 1'b1;
                  mul_en     <= 1'b0;
                  state      <= IDLE;
               end else begin
                  timer <= timer + 16'd1;
`endif
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_issue_ctrl.sv
// Directed bench for booth_mul_issue_ctrl with a behavioural multiplier and a product scoreboard.
// Timeout checks run only when BOOTH_ISSUE_TIMEOUT_EN is defined.
module tb_booth_mul_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_en;
   logic        mul_reset;
   logic [63:0] mul_result;
   logic        mul_done;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_result;
   logic        out_err;

   logic        force_hi = 1'b0;
   logic        force_lo = 1'b0;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [64:0] sb [$];

   always #5 clk = ~clk;

   booth_mul_issue_ctrl #(.FIFO_DEPTH(4), .MUL_TIMEOUT(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_en     (mul_en),
      .mul_reset  (mul_reset),
      .mul_result (mul_result),
      .mul_done   (mul_done),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_err    (out_err)
   );

   // Behavioural multiplier: restarts on mul_reset, done 17 enabled edges later, done also while disabled.
   logic [4:0]         mcnt;
   logic signed [63:0] mprod;
   logic               model_done;

   always_ff @(posedge clk) begin
      if (mul_reset) mcnt <= 5'd0;
      else if (mul_en && mcnt != 5'd17) mcnt <= mcnt + 5'd1;
   end

   assign mprod      = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
   assign model_done = !mul_en || (mcnt == 5'd17 && !mul_reset);
   assign mul_done   = force_hi ? 1'b1 : (force_lo ? 1'b0 : model_done);
   assign mul_result = (mcnt == 5'd17) ? mprod : 64'hBADB_ADBA_DBAD_BAD0;

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL spurious_product: observed %h expected none", out_result);
         end else begin
            check("product", {out_err, out_result}, sb.pop_front());
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic exp_err);
      logic               rdy;
      logic signed [63:0] p;
      int                 k;
      k = 0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      do begin
         rdy = in_ready;
         @(posedge clk);
         k++;
      end while (!rdy && k < 200);
      #1;
      in_valid = 1'b0;
      if (rdy) begin
         p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         sb.push_back(exp_err ? {1'b1, 64'd0} : {1'b0, p});
      end else begin
         check("push_timeout", {64'd0, rdy}, 65'd1);
      end
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int k;
      k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      check(tag, 65'(sb.size()), 65'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset values while held in reset.
      tick(3);
      check("rst_in_ready", {64'd0, in_ready}, 65'd0);
      check("rst_mul_ctl", {63'd0, mul_en, mul_reset}, 65'd0);
      check("rst_mul_ab", {1'b0, mul_a, mul_b}, 65'd0);
      check("rst_out", {out_err, out_result}, 65'd0);
      check("rst_out_valid", {64'd0, out_valid}, 65'd0);
      reset = 1'b1;
      #1;
      check("rel_in_ready", {64'd0, in_ready}, 65'd1);
      tick(2);

      // Latency of a single product: 3 * 5.
      out_ready = 1'b1;
      push(32'd3, 32'd5, 1'b0);
      check("lat_e0_mul_en", {64'd0, mul_en}, 65'd0);
      tick(1);
      check("lat_e1_ctl", {63'd0, mul_en, mul_reset}, 65'd3);
      check("lat_e1_ab", {1'b0, mul_a, mul_b}, {1'b0, 32'd3, 32'd5});
      tick(1);
      check("lat_e2_ctl", {63'd0, mul_en, mul_reset}, 65'd2);
      tick(17);
      check("lat_e19_valid", {64'd0, out_valid}, 65'd0);
      tick(1);
      check("lat_e20_valid", {64'd0, out_valid}, 65'd1);
      check("lat_e20_result", {out_err, out_result}, {1'b0, 64'h0000_0000_0000_000F});
      check("lat_e20_mul_en", {64'd0, mul_en}, 65'd0);
      wait_drain("drain_lat", 100);

      // Stale mul_done in IDLE and RST must not capture.
      force_hi = 1'b1;
      tick(5);
      check("force_idle_valid", {64'd0, out_valid}, 65'd0);
      push(32'd2, 32'd2, 1'b0);
      tick(1);
      check("force_rst_valid", {64'd0, out_valid}, 65'd0);
      tick(1);
      force_hi = 1'b0;
      check("force_run_valid", {64'd0, out_valid}, 65'd0);
      wait_drain("drain_force", 100);

      // Sign and extreme operands.
      push(32'hFFFF_FFF9, 32'd6, 1'b0);
      push(32'h8000_0000, 32'h8000_0000, 1'b0);
      check("sb_signed_exp", sb[0], {1'b0, 64'hFFFF_FFFF_FFFF_FFD6});
      check("sb_min_exp", sb[1], {1'b0, 64'h4000_0000_0000_0000});
      wait_drain("drain_signed", 200);

      // Back-pressure: five pairs, consumer stalled.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push(32'(i * 123457 - 50000), 32'(-(i * 7 + 3)), 1'b0);
      end
      check("bp_full", {64'd0, in_ready}, 65'd0);
      tick(30);
      check("bp_held", {62'd0, out_valid, mul_en, in_ready}, 65'b100);
      out_ready = 1'b1;
      wait_drain("drain_bp", 400);
      check("bp_in_ready", {64'd0, in_ready}, 65'd1);

      // Reset in the middle of a multiply with two pairs queued.
      push(32'd5, 32'd7, 1'b0);
      push(32'd8, 32'd9, 1'b0);
      push(32'd10, 32'd11, 1'b0);
      tick(9);
      check("mid_run_mul_en", {64'd0, mul_en}, 65'd1);
      reset = 1'b0;
      sb.delete();
      #1;
      check("mid_rst_ctl", {62'd0, in_ready, mul_en, mul_reset}, 65'd0);
      check("mid_rst_ab", {1'b0, mul_a, mul_b}, 65'd0);
      check("mid_rst_out", {out_err, out_result}, 65'd0);
      check("mid_rst_valid", {64'd0, out_valid}, 65'd0);
      tick(2);
      reset = 1'b1;
      tick(40);
      check("post_rst_idle", {63'd0, out_valid, mul_en}, 65'd0);
      push(32'd2, 32'd2, 1'b0);
      check("sb_post_rst_exp", sb[0], {1'b0, 64'd4});
      wait_drain("drain_post_rst", 100);

`ifdef BOOTH_ISSUE_TIMEOUT_EN
      // Watchdog abort exactly 32 cycles after RUN entry.
      force_lo = 1'b1;
      push(32'd9, 32'd9, 1'b1);
      tick(33);
      check("to_e33_valid", {64'd0, out_valid}, 65'd0);
      tick(1);
      check("to_e34_valid", {64'd0, out_valid}, 65'd1);
      check("to_e34_out", {out_err, out_result}, {1'b1, 64'd0});
      force_lo = 1'b0;
      wait_drain("drain_to", 100);
      push(32'd6, 32'd7, 1'b0);
      wait_drain("drain_after_to", 100);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench watchdog expired");
   end

endmodule
